// File: rtl/inst_buffer_pkg.sv
//------------------------------------------------------------------------------
// Module   : inst_buffer_pkg
// Purpose  : Shared constants and types for the IF->ID instruction buffer:
//            default geometry, entry width and pc/inst field offsets.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package inst_buffer_pkg;

  // Default buffer geometry
  localparam int C_IB_DEPTH    = 16;
  localparam int C_IB_PUSH_W   = 2;
  localparam int C_IB_POP_W    = 2;
  localparam int C_IB_ENTRY_WD = 64;

  // Field placement inside one entry: {pc[31:0], inst[31:0]}
  localparam int C_IB_INST_LSB = 0;
  localparam int C_IB_INST_WD  = 32;
  localparam int C_IB_PC_LSB   = 32;
  localparam int C_IB_PC_WD    = 32;

  typedef struct packed {
    logic [C_IB_PC_WD-1:0]   pc;
    logic [C_IB_INST_WD-1:0] inst;
  } ib_entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_buffer_if.sv
//------------------------------------------------------------------------------
// Module   : inst_buffer_if
// Purpose  : Push (IF side) and pop (ID side) bundle of the instruction buffer.
//            master = fetch/issue logic, slave = the buffer itself.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface inst_buffer_if
  import inst_buffer_pkg::*;
#(
  parameter int PUSH_W   = C_IB_PUSH_W,
  parameter int POP_W    = C_IB_POP_W,
  parameter int ENTRY_WD = C_IB_ENTRY_WD
);

  localparam int C_NUM_W = $clog2(POP_W + 1);

  logic [PUSH_W-1:0]          push_valid;
  logic [PUSH_W*ENTRY_WD-1:0] push_data;
  logic                       push_ready;
  logic [POP_W-1:0]           pop_valid;
  logic [POP_W*ENTRY_WD-1:0]  pop_data;
  logic [C_NUM_W-1:0]         pop_num;

  modport master (
    output push_valid, push_data, pop_num,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_num,
    output push_ready, pop_valid, pop_data
  );

endinterface

`default_nettype wire

// File: rtl/inst_buffer_compact.sv
//------------------------------------------------------------------------------
// Module   : ib_compact
// Purpose  : Lane compaction helper. Counts the valid push lanes and gives each
//            lane its write offset (number of valid lanes below it).
//            Purely combinational.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ib_compact #(
  parameter  int PUSH_W = 2,
  localparam int CNT_W  = $clog2(PUSH_W + 1)
) (
  input  wire logic [PUSH_W-1:0]       i_valid,
  output logic      [CNT_W-1:0]        o_npush,
  output logic      [PUSH_W*CNT_W-1:0] o_offset
);

  logic [CNT_W-1:0] w_acc;

  // Prefix popcount: lane i lands at offset = valid lanes strictly below i
  always_comb begin
    w_acc    = '0;
    o_offset = '0;
    for (int i = 0; i < PUSH_W; i++) begin
      o_offset[i*CNT_W +: CNT_W] = w_acc;
      w_acc = w_acc + CNT_W'(i_valid[i]);
    end
    o_npush = w_acc;
  end

endmodule

`default_nettype wire

// File: rtl/inst_buffer.sv
//------------------------------------------------------------------------------
// Module   : inst_buffer
// Purpose  : Multi-lane circular instruction buffer between IF and ID.
//            Up to PUSH_W compacted entries written per cycle, up to POP_W
//            entries presented/consumed per cycle in program order, flush.
//            Optional macro IB_BYPASS_EN: when empty, pushed entries are
//            presented on the pop lanes in the same cycle and consumed ones
//            are never written.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH    = C_IB_DEPTH,
  parameter int PUSH_W   = C_IB_PUSH_W,
  parameter int POP_W    = C_IB_POP_W,
  parameter int ENTRY_WD = C_IB_ENTRY_WD
) (
  input  wire logic                  aclk,
  input  wire logic                  aresetn,
  input  wire logic                  flush,
  inst_buffer_if.slave               bus,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = C_AW + 1;
  localparam int C_PW = $clog2(PUSH_W + 1);
  localparam int C_LW = (PUSH_W > POP_W) ? PUSH_W : POP_W;

  logic [ENTRY_WD-1:0]        r_mem [DEPTH];
  logic [C_AW-1:0]            r_head;
  logic [C_AW-1:0]            r_tail;
  logic [C_CW-1:0]            r_count;

  logic                       w_push_ready;
  logic [C_PW-1:0]            w_npush;
  logic [PUSH_W*C_PW-1:0]     w_offset;
  logic [C_CW-1:0]            w_npush_acc;
  logic [C_CW-1:0]            w_pop_req;
  logic [C_CW-1:0]            w_npop;
  logic [C_CW-1:0]            w_nskip;
  logic [C_CW-1:0]            w_nwrite;
  logic [C_CW-1:0]            w_off;
  logic [PUSH_W-1:0]          w_we;
  logic [C_AW-1:0]            w_waddr [PUSH_W];
  logic [POP_W-1:0]           w_pop_valid;
  logic [POP_W*ENTRY_WD-1:0]  w_pop_data;

  ib_compact #(
    .PUSH_W (PUSH_W)
  ) u_compact (
    .i_valid  (bus.push_valid),
    .o_npush  (w_npush),
    .o_offset (w_offset)
  );

  // Room for a full push group is judged on the registered count only
  assign w_push_ready = (C_CW'(DEPTH) - r_count) >= C_CW'(PUSH_W);
  assign w_npush_acc  = w_push_ready ? C_CW'(w_npush) : '0;
  assign w_pop_req    = C_CW'(bus.pop_num);

  // Stored entries consumed this cycle, clamped to what is held
  always_comb begin
    w_npop = (w_pop_req < r_count) ? w_pop_req : r_count;
  end

`ifdef IB_BYPASS_EN
  logic                       w_byp_act;
  logic [C_LW*ENTRY_WD-1:0]   w_cmp_data;

  assign w_byp_act = (r_count == '0) && !flush;

  // Compacted view of the push lanes, used to feed the pop lanes when empty
  always_comb begin
    w_cmp_data = '0;
    for (int i = 0; i < PUSH_W; i++) begin
      if (bus.push_valid[i]) begin
        w_cmp_data[int'(w_offset[i*C_PW +: C_PW])*ENTRY_WD +: ENTRY_WD] =
          bus.push_data[i*ENTRY_WD +: ENTRY_WD];
      end
    end
  end

  // Entries handed straight to ID and therefore never written
  always_comb begin
    w_nskip = '0;
    if (w_byp_act) begin
      w_nskip = (w_pop_req < w_npush_acc) ? w_pop_req : w_npush_acc;
    end
  end

  // Pop lanes: live push group when empty, otherwise the stored oldest entries
  always_comb begin
    w_pop_valid = '0;
    w_pop_data  = '0;
    for (int i = 0; i < POP_W; i++) begin
      if (w_byp_act) begin
        w_pop_valid[i] = C_CW'(i) < w_npush_acc;
        w_pop_data[i*ENTRY_WD +: ENTRY_WD] = w_cmp_data[i*ENTRY_WD +: ENTRY_WD];
      end else begin
        w_pop_valid[i] = r_count > C_CW'(i);
        w_pop_data[i*ENTRY_WD +: ENTRY_WD] = r_mem[r_head + C_AW'(i)];
      end
    end
  end
`else
  assign w_nskip = '0;

  // Pop lanes show the oldest stored entries; no path from the push side
  always_comb begin
    w_pop_valid = '0;
    w_pop_data  = '0;
    for (int i = 0; i < POP_W; i++) begin
      w_pop_valid[i] = r_count > C_CW'(i);
      w_pop_data[i*ENTRY_WD +: ENTRY_WD] = r_mem[r_head + C_AW'(i)];
    end
  end
`endif

  assign w_nwrite = w_npush_acc - w_nskip;

  // Per-lane write enables and compacted addresses relative to tail
  always_comb begin
    w_off = '0;
    w_we  = '0;
    for (int i = 0; i < PUSH_W; i++) begin
      w_off      = C_CW'(w_offset[i*C_PW +: C_PW]);
      w_we[i]    = bus.push_valid[i] && w_push_ready && !flush && aresetn &&
                   (w_off >= w_nskip);
      w_waddr[i] = r_tail + C_AW'(w_off - w_nskip);
    end
  end

  // Pointer and occupancy update; flush and reset discard the whole cycle
  always_ff @(posedge aclk) begin
    if (!aresetn || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + C_AW'(w_npop);
      r_tail  <= r_tail + C_AW'(w_nwrite);
      r_count <= r_count + w_nwrite - w_npop;
    end
  end

  // Entry storage; contents are don't-care after reset
  always_ff @(posedge aclk) begin
    for (int i = 0; i < PUSH_W; i++) begin
      if (w_we[i]) begin
        r_mem[w_waddr[i]] <= bus.push_data[i*ENTRY_WD +: ENTRY_WD];
      end
    end
  end

  assign bus.push_ready = w_push_ready;
  assign bus.pop_valid  = w_pop_valid;
  assign bus.pop_data   = w_pop_data;
  assign empty          = (r_count == '0);
  assign count          = r_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_buffer.sv
//------------------------------------------------------------------------------
// Module   : tb_inst_buffer
// Purpose  : Directed self-checking bench for inst_buffer (DEPTH=8, 2x2 lanes).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_buffer;

  localparam int C_DEPTH = 8;
  localparam int C_EW    = 64;

  typedef struct {
    logic [1:0] pv;
    int         d0;
    int         d1;
    int         pn;
    int         ecnt;
    logic [1:0] epv;
    int         el0;
    int         el1;
  } vec_t;

  logic       aclk;
  logic       aresetn;
  logic       flush;
  logic       empty;
  logic [3:0] count;

  int n_chk;
  int n_fail;

  vec_t tv [19];

  inst_buffer_if #(.PUSH_W(2), .POP_W(2), .ENTRY_WD(C_EW)) u_bus ();

  inst_buffer #(
    .DEPTH    (C_DEPTH),
    .PUSH_W   (2),
    .POP_W    (2),
    .ENTRY_WD (C_EW)
  ) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .flush   (flush),
    .bus     (u_bus),
    .empty   (empty),
    .count   (count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Unique {pc, inst} pattern per entry id
  function automatic logic [63:0] ent(int n);
    logic [31:0] v_pc;
    logic [31:0] v_in;
    v_pc = 32'h0000_1000 + 32'(n) * 32'd4;
    v_in = 32'hA500_0000 + 32'(n);
    return {v_pc, v_in};
  endfunction

  function automatic vec_t mkv(logic [1:0] pv, int d0, int d1, int pn,
                               int ecnt, logic [1:0] epv, int el0, int el1);
    vec_t v;
    v.pv = pv; v.d0 = d0; v.d1 = d1; v.pn = pn;
    v.ecnt = ecnt; v.epv = epv; v.el0 = el0; v.el1 = el1;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock with the given inputs; samples are taken 1 time unit after the edge
  task automatic step(logic rstn, logic fl, logic [1:0] pv, int d0, int d1, int pn);
    aresetn = rstn;
    flush   = fl;
    u_bus.push_valid = pv;
    u_bus.push_data  = {ent(d1), ent(d0)};
    u_bus.pop_num    = 2'(pn);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    flush   = 1'b0;
    u_bus.push_valid = 2'b00;
    u_bus.pop_num    = 2'd0;
  endtask

  task automatic check_state(string tag, int ecnt, logic [1:0] epv, int el0, int el1);
    logic v_pr;
    logic v_em;
    v_pr = (C_DEPTH - ecnt) >= 2;
    v_em = (ecnt == 0);
    chk($sformatf("%s.count", tag), 64'(count), 64'(ecnt));
    chk($sformatf("%s.pop_valid", tag), 64'(u_bus.pop_valid), 64'(epv));
    chk($sformatf("%s.empty", tag), 64'(empty), 64'(v_em));
    chk($sformatf("%s.push_ready", tag), 64'(u_bus.push_ready), 64'(v_pr));
    if (epv[0]) chk($sformatf("%s.lane0", tag), u_bus.pop_data[63:0], ent(el0));
    if (epv[1]) chk($sformatf("%s.lane1", tag), u_bus.pop_data[127:64], ent(el1));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    aresetn = 1'b0;
    flush   = 1'b0;
    u_bus.push_valid = 2'b00;
    u_bus.push_data  = '0;
    u_bus.pop_num    = 2'd0;

    // Fill, overflow attempt, wrap-around drain, compaction and clamped pops
    tv[0]  = mkv(2'b11,  1,  2, 0, 2, 2'b11,  1,  2);
    tv[1]  = mkv(2'b11,  3,  4, 0, 4, 2'b11,  1,  2);
    tv[2]  = mkv(2'b11,  5,  6, 0, 6, 2'b11,  1,  2);
    tv[3]  = mkv(2'b11,  7,  8, 0, 8, 2'b11,  1,  2);
    tv[4]  = mkv(2'b11,  9, 10, 0, 8, 2'b11,  1,  2);
    tv[5]  = mkv(2'b00,  0,  0, 2, 6, 2'b11,  3,  4);
    tv[6]  = mkv(2'b00,  0,  0, 2, 4, 2'b11,  5,  6);
    tv[7]  = mkv(2'b11, 11, 12, 0, 6, 2'b11,  5,  6);
    tv[8]  = mkv(2'b11, 13, 14, 0, 8, 2'b11,  5,  6);
    tv[9]  = mkv(2'b00,  0,  0, 2, 6, 2'b11,  7,  8);
    tv[10] = mkv(2'b00,  0,  0, 2, 4, 2'b11, 11, 12);
    tv[11] = mkv(2'b00,  0,  0, 2, 2, 2'b11, 13, 14);
    tv[12] = mkv(2'b00,  0,  0, 2, 0, 2'b00,  0,  0);
    tv[13] = mkv(2'b10, 99, 15, 0, 1, 2'b01, 15,  0);
    tv[14] = mkv(2'b00,  0,  0, 2, 0, 2'b00,  0,  0);
    tv[15] = mkv(2'b11, 16, 17, 0, 2, 2'b11, 16, 17);
    tv[16] = mkv(2'b00,  0,  0, 1, 1, 2'b01, 17,  0);
    tv[17] = mkv(2'b01, 18, 99, 0, 2, 2'b11, 17, 18);
    tv[18] = mkv(2'b00,  0,  0, 2, 0, 2'b00,  0,  0);

    step(1'b0, 1'b0, 2'b00, 0, 0, 0);
    step(1'b0, 1'b0, 2'b00, 0, 0, 0);
    check_state("reset", 0, 2'b00, 0, 0);

    for (int i = 0; i < 19; i++) begin
      step(1'b1, 1'b0, tv[i].pv, tv[i].d0, tv[i].d1, tv[i].pn);
      check_state($sformatf("v%0d", i), tv[i].ecnt, tv[i].epv, tv[i].el0, tv[i].el1);
    end

    // Simultaneous push and pop with count=3
    step(1'b1, 1'b0, 2'b11, 20, 21, 0);
    step(1'b1, 1'b0, 2'b01, 22, 99, 0);
    check_state("pp.pre", 3, 2'b11, 20, 21);
    step(1'b1, 1'b0, 2'b11, 23, 24, 1);
    check_state("pp.both", 4, 2'b11, 21, 22);
    step(1'b1, 1'b0, 2'b00, 0, 0, 2);
    check_state("pp.pop1", 2, 2'b11, 23, 24);
    step(1'b1, 1'b0, 2'b00, 0, 0, 2);
    check_state("pp.pop2", 0, 2'b00, 0, 0);

    // Flush with concurrent push and pop at count=5
    step(1'b1, 1'b0, 2'b11, 30, 31, 0);
    step(1'b1, 1'b0, 2'b11, 32, 33, 0);
    step(1'b1, 1'b0, 2'b01, 34, 99, 0);
    check_state("fl.pre", 5, 2'b11, 30, 31);
    step(1'b1, 1'b1, 2'b11, 35, 36, 2);
    check_state("fl.post", 0, 2'b00, 0, 0);
    step(1'b1, 1'b0, 2'b11, 37, 38, 0);
    check_state("fl.reuse", 2, 2'b11, 37, 38);

    // Reset mid-operation with concurrent push and pop at count=5
    step(1'b1, 1'b0, 2'b01, 39, 99, 0);
    step(1'b1, 1'b0, 2'b11, 40, 41, 0);
    check_state("rs.pre", 5, 2'b11, 37, 38);
    step(1'b0, 1'b0, 2'b11, 42, 43, 2);
    check_state("rs.post", 0, 2'b00, 0, 0);
    step(1'b1, 1'b0, 2'b11, 44, 45, 0);
    check_state("rs.reuse", 2, 2'b11, 44, 45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Parametrised multi-lane instruction buffer between the IF stage and the ID stage of the dual-issue core.
- Generalises the fixed two-instruction IF/ID hand-off: configurable depth, configurable fetch (push) and issue (pop) lane counts, lane compaction, and flush.
- IF pushes up to PUSH_W {pc, inst} entries per cycle. ID pops 0..POP_W entries per cycle in program order.

Parameters:
DEPTH, 16, entry count; power of 2; must be >= PUSH_W+POP_W
PUSH_W, 2, fetch lanes written per cycle
POP_W, 2, issue lanes presented per cycle
ENTRY_WD, 64, bits per entry ({pc[31:0], inst[31:0]})

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
flush  in  1  discard all contents (branch/exception redirect)
push_valid  in  PUSH_W  per-lane entry valid from IF
push_data  in  PUSH_W*ENTRY_WD  lane i at [i*ENTRY_WD +: ENTRY_WD]
push_ready  out  1  buffer can accept a full PUSH_W group this cycle
pop_valid  out  POP_W  lane i holds a valid entry
pop_data  out  POP_W*ENTRY_WD  oldest entries; lane 0 is oldest
pop_num  in  clog2(POP_W+1)  number of entries ID consumes this cycle
empty  out  1  count == 0
count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: circular array `mem[DEPTH]`, pointers `head` (read) and `tail` (write), each clog2(DEPTH) bits. Pointers wrap modulo DEPTH naturally. `count` is a separate register.
- Reset (aresetn==0 at posedge aclk): head=tail=count=0. Outputs then: pop_valid=0, empty=1, push_ready=1, count=0. Memory contents are don't-care.
- push_ready = (DEPTH - count) >= PUSH_W. Combinational from registered count; does not depend on the current pop.
- Push:
  - Accepted only when push_ready=1. When push_ready=0 the push is ignored and state is unchanged; IF must hold.
  - npush = popcount(push_valid).
  - Valid lanes are compacted in ascending lane order: the k-th valid lane is written to mem[tail+k].
  - tail += npush.
- Pop outputs:
  - pop_valid[i] = (count > i).
  - pop_data lane i = mem[head+i] (wraps).
  - Combinational from registers; no bypass of same-cycle pushes (see Optional Feature).
- Pop consumption:
  - npop = min(pop_num, count). A request exceeding count is clamped, never underflows.
  - head += npop.
- Simultaneous push and pop: count_next = count + npush_accepted - npop. Full and empty conditions are judged on the pre-update count.
- Flush has highest priority: head=tail=count=0 next cycle; push and pop in the same cycle are discarded.
- Reset mid-operation: identical to flush plus output reset values.
- Latency: a pushed entry is visible on pop lanes the cycle after acceptance.
- Order is always preserved across wrap-around.

Optional Feature:
- Macro: IB_BYPASS_EN.
- Enabled: when count==0 and flush==0:
  - the compacted push lanes drive pop_valid/pop_data in the same cycle;
  - the first min(npush, pop_num) lanes are consumed directly and never written;
  - the remainder is written starting at tail.
- Disabled: one-cycle minimum latency as above; no combinational path from push_* to pop_*.

Decomposition:
- Shared header (alongside the existing bus-width defines):
  - `IB_ENTRY_WD`, default DEPTH/lane constants;
  - pc/inst field offsets within an entry.
- One sub-module, ib_compact:
  - input: push_valid;
  - outputs: npush and per-lane write offset (prefix popcount);
  - purely combinational, reused by the bypass path.

Test Plan (DEPTH=8, PUSH_W=2, POP_W=2):
1. Reset, push lanes {A,B} valid=2'b11, pop_num=0 -> next cycle count=2, pop_valid=2'b11, lane0=A, lane1=B, empty=0.
2. Push pairs for 4 cycles, pop_num=0 -> count=8, push_ready=0; 5th push {X,Y} ignored, count stays 8, contents unchanged.
3. Wrap-around: fill to 8, pop 2 per cycle twice, push 2 pairs -> tail wraps past index 7; popping all 8 returns entries in push order.
4. count=3, push 2'b11 with pop_num=1 in the same cycle -> count=4, head advanced by 1, new entries at the former tail.
5. Compaction: push_valid=2'b10, lane1=C into an empty buffer -> count=1, pop_valid=2'b01, lane0=C. Also: pop_num=2 with count=1 -> count=0, no underflow.
6. count=5, flush=1 together with push 2'b11 and pop_num=2 -> next cycle count=0, empty=1, push_ready=1. Repeat with aresetn=0 -> same result.
